// File: rtl/rv_mem_pkg.sv
// Shared constants for the data-memory subsystem: MMIO register offsets,
// STATUS bit layout and the address-region decode enumeration.
package rv_mem_pkg;

  localparam logic [3:0] CONSOLE_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS  = 4'h4;
  localparam logic [3:0] HALT_OFS    = 4'h8;

  localparam int STAT_CNT_MSB  = 7;
  localparam int STAT_FULL_BIT = 8;
  localparam int STAT_OVF_BIT  = 9;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // MMIO registers are word-wide, so only offset bits [3:2] select one
  function automatic logic [1:0] mmio_word(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

endpackage

// File: rtl/rv_dmem_mmio_if.sv
// Core data-port bus plus the console valid/ready drain port.
// master = core/testbench side, slave = rv_dmem_mmio.
interface rv_dmem_mmio_if #(
  parameter int DPWIDTH = 32
);
  logic [DPWIDTH-1:0] dmem_addr;
  logic [DPWIDTH-1:0] dmem_dataout;
  logic               memrw;
  logic [DPWIDTH-1:0] dmem_datain;
  logic [7:0]         con_data;
  logic               con_valid;
  logic               con_ready;

  modport master (
    output dmem_addr, dmem_dataout, memrw, con_ready,
    input  dmem_datain, con_data, con_valid
  );

  modport slave (
    input  dmem_addr, dmem_dataout, memrw, con_ready,
    output dmem_datain, con_data, con_valid
  );
endinterface

// File: rtl/rv_byte_fifo.sv
// 8-bit console FIFO with sticky overflow flag; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module rv_byte_fifo #(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop_ready,
  output logic          valid,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];
  logic          pop;
  logic          push_ok;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = valid && pop_ready;
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    ovf_d    = ovf_q | (push && full && !pop);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // When full with a simultaneous pop, wr_ptr == rd_ptr: the head is read
  // this cycle and overwritten at the edge, after which rd_ptr moves on.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = valid ? mem_q[rd_ptr_q] : 8'h00;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/rv_dmem_mmio.sv
// Data memory behind the multicycle RISC-V core: word RAM, HALT register and,
// when RV_MMIO_CONSOLE_EN is defined, a memory-mapped console byte FIFO.
module rv_dmem_mmio
  import rv_mem_pkg::*;
#(
  parameter int                 DPWIDTH   = 32,
  parameter int                 RAMWORDS  = 1024,
  parameter int                 FIFODEPTH = 8,
  parameter logic [DPWIDTH-1:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic               clk,
  input  logic               rst,
  rv_dmem_mmio_if.slave      bus,
  output logic               halt,
  output logic [DPWIDTH-1:0] halt_code,
  output logic               con_ovf
);

  localparam int                 RAW       = $clog2(RAMWORDS);
  localparam logic [DPWIDTH-1:0] RAM_BYTES = DPWIDTH'(RAMWORDS * 4);

  region_e            region;
  logic [RAW-1:0]     ram_idx;
  logic [1:0]         mmio_sel;
  logic               wr_ram;
  logic               wr_con;
  logic               wr_halt;
  logic [DPWIDTH-1:0] status_w;
  logic [DPWIDTH-1:0] ram_q [RAMWORDS];

  logic               halt_q, halt_d;
  logic [DPWIDTH-1:0] halt_code_q, halt_code_d;

  always_comb begin
    region = REG_NONE;
    if (bus.dmem_addr < RAM_BYTES)
      region = REG_RAM;
    else if (bus.dmem_addr[DPWIDTH-1:4] == MMIO_BASE[DPWIDTH-1:4])
      region = REG_MMIO;
  end

  assign ram_idx  = bus.dmem_addr[RAW+1:2];
  assign mmio_sel = bus.dmem_addr[3:2];

  assign wr_ram  = bus.memrw && (region == REG_RAM);
  assign wr_con  = bus.memrw && (region == REG_MMIO) && (mmio_sel == mmio_word(CONSOLE_OFS));
  assign wr_halt = bus.memrw && (region == REG_MMIO) && (mmio_sel == mmio_word(HALT_OFS));

  always_ff @(posedge clk) begin
    if (wr_ram) ram_q[ram_idx] <= bus.dmem_dataout;
  end

  // First HALT write wins; later ones are ignored until reset
  always_comb begin
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    if (wr_halt && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = bus.dmem_dataout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

  assign halt      = halt_q;
  assign halt_code = halt_code_q;

`ifdef RV_MMIO_CONSOLE_EN
  logic [$clog2(FIFODEPTH):0] fifo_count;
  logic                       fifo_full;
  logic                       fifo_ovf;
  logic                       fifo_valid;
  logic [7:0]                 fifo_head;

  rv_byte_fifo #(.DEPTH(FIFODEPTH)) u_con_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_con),
    .push_data (bus.dmem_dataout[7:0]),
    .pop_ready (bus.con_ready),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .ovf       (fifo_ovf)
  );

  assign bus.con_valid = fifo_valid;
  assign bus.con_data  = fifo_head;
  assign con_ovf       = fifo_ovf;

  always_comb begin
    status_w                 = '0;
    status_w[STAT_CNT_MSB:0] = 8'(fifo_count);
    status_w[STAT_FULL_BIT]  = fifo_full;
    status_w[STAT_OVF_BIT]   = fifo_ovf;
  end
`else
  logic unused_console;

  assign unused_console = bus.con_ready ^ wr_con;
  assign bus.con_valid  = 1'b0;
  assign bus.con_data   = 8'h00;
  assign con_ovf        = 1'b0;
  assign status_w       = '0;
`endif

  always_comb begin
    bus.dmem_datain = '0;
    if (region == REG_RAM) begin
      bus.dmem_datain = ram_q[ram_idx];
    end else if (region == REG_MMIO) begin
      if (mmio_sel == mmio_word(STATUS_OFS))
        bus.dmem_datain = status_w;
      else if (mmio_sel == mmio_word(HALT_OFS))
        bus.dmem_datain = halt_code_q;
    end
  end

endmodule

// File: tb/tb_rv_dmem_mmio.sv
// Directed bench for rv_dmem_mmio; console scenarios follow RV_MMIO_CONSOLE_EN.
module tb_rv_dmem_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] CON  = BASE + 32'h0;
  localparam logic [31:0] STAT = BASE + 32'h4;
  localparam logic [31:0] HLT  = BASE + 32'h8;
  localparam logic [31:0] RSV  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt;
  logic [31:0] halt_code;
  logic        con_ovf;
  logic [31:0] rd;
  int          total  = 0;
  int          passed = 0;

  rv_dmem_mmio_if #(.DPWIDTH(32)) bus ();

  rv_dmem_mmio #(
    .DPWIDTH   (32),
    .RAMWORDS  (1024),
    .FIFODEPTH (8),
    .MMIO_BASE (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .halt      (halt),
    .halt_code (halt_code),
    .con_ovf   (con_ovf)
  );

  always #5 clk = ~clk;

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.dmem_addr    = a;
    bus.dmem_dataout = d;
    bus.memrw        = 1'b1;
    @(negedge clk);
    bus.memrw = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.memrw     = 1'b0;
    bus.dmem_addr = a;
    #1;
    v = bus.dmem_datain;
  endtask

  task automatic test_reset();
    bus.dmem_addr    = 32'h0;
    bus.dmem_dataout = 32'h0;
    bus.memrw        = 1'b0;
    bus.con_ready    = 1'b0;
    rst              = 1'b0;
    repeat (3) @(negedge clk);
    bus.dmem_addr = STAT;
    #1;
    total++; if (halt !== 1'b0) $display("FAIL reset_halt got %0h exp 0", halt); else passed++;
    total++; if (halt_code !== 32'h0) $display("FAIL reset_halt_code got %h exp 0", halt_code); else passed++;
    total++; if (con_ovf !== 1'b0) $display("FAIL reset_con_ovf got %0h exp 0", con_ovf); else passed++;
    total++; if (bus.con_valid !== 1'b0) $display("FAIL reset_con_valid got %0h exp 0", bus.con_valid); else passed++;
    total++; if (bus.con_data !== 8'h00) $display("FAIL reset_con_data got %h exp 00", bus.con_data); else passed++;
    total++; if (bus.dmem_datain !== 32'h0) $display("FAIL reset_status got %h exp 0", bus.dmem_datain); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ram();
    store(32'h40, 32'hDEAD_BEEF);
    load(32'h40, rd);
    total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL ram_40 got %h exp deadbeef", rd); else passed++;
    store(32'h47, 32'h1234_5678);
    load(32'h44, rd);
    total++; if (rd !== 32'h1234_5678) $display("FAIL ram_byte_ofs got %h exp 12345678", rd); else passed++;
    load(32'h40, rd);
    total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL ram_neighbour got %h exp deadbeef", rd); else passed++;
    store(32'hFFC, 32'hA5A5_5A5A);
    load(32'hFFC, rd);
    total++; if (rd !== 32'hA5A5_5A5A) $display("FAIL ram_last_word got %h exp a5a55a5a", rd); else passed++;
    store(32'h0, 32'h1111_1111);
    store(32'h1000, 32'hFFFF_FFFF);
    load(32'h1000, rd);
    total++; if (rd !== 32'h0) $display("FAIL unmapped_1000 got %h exp 0", rd); else passed++;
    load(32'h0, rd);
    total++; if (rd !== 32'h1111_1111) $display("FAIL ram_alias_guard got %h exp 11111111", rd); else passed++;
    load(32'h2000, rd);
    total++; if (rd !== 32'h0) $display("FAIL unmapped_2000 got %h exp 0", rd); else passed++;
    load(RSV, rd);
    total++; if (rd !== 32'h0) $display("FAIL mmio_reserved got %h exp 0", rd); else passed++;
    load(CON, rd);
    total++; if (rd !== 32'h0) $display("FAIL console_read got %h exp 0", rd); else passed++;
  endtask

  task automatic test_halt();
    total++; if (halt !== 1'b0) $display("FAIL halt_pre got %0h exp 0", halt); else passed++;
    store(HLT, 32'h1);
    total++; if (halt !== 1'b1) $display("FAIL halt_set got %0h exp 1", halt); else passed++;
    total++; if (halt_code !== 32'h1) $display("FAIL halt_code_first got %h exp 1", halt_code); else passed++;
    store(HLT, 32'h7);
    total++; if (halt_code !== 32'h1) $display("FAIL halt_code_sticky got %h exp 1", halt_code); else passed++;
    load(HLT, rd);
    total++; if (rd !== 32'h1) $display("FAIL halt_read got %h exp 1", rd); else passed++;
    store(32'h80, 32'h0000_CAFE);
    load(32'h80, rd);
    total++; if (rd !== 32'h0000_CAFE) $display("FAIL ram_after_halt got %h exp cafe", rd); else passed++;
  endtask

`ifdef RV_MMIO_CONSOLE_EN
  task automatic test_console();
    logic [7:0] b;
    bus.con_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = (i == 0) ? 8'h4F : (i == 1) ? 8'h4B : 8'h0A;
      store(CON, {24'h0, b});
      total++;
      if ({bus.con_valid, bus.con_data} !== {1'b1, b})
        $display("FAIL console_byte%0d got v=%0h d=%h exp v=1 d=%h", i, bus.con_valid, bus.con_data, b);
      else passed++;
    end
    @(negedge clk);
    total++; if (bus.con_valid !== 1'b0) $display("FAIL console_empty got %0h exp 0", bus.con_valid); else passed++;
    bus.con_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] e;
    bus.con_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(CON, 32'h20 + i);
    load(STAT, rd);
    total++; if (rd !== 32'h108) $display("FAIL fpp_status_full got %h exp 108", rd); else passed++;
    @(negedge clk);
    bus.con_ready    = 1'b1;
    bus.dmem_addr    = CON;
    bus.dmem_dataout = 32'h55;
    bus.memrw        = 1'b1;
    #1;
    total++; if (bus.con_data !== 8'h20) $display("FAIL fpp_head got %h exp 20", bus.con_data); else passed++;
    @(negedge clk);
    bus.memrw     = 1'b0;
    bus.con_ready = 1'b0;
    bus.dmem_addr = STAT;
    #1;
    total++; if (bus.dmem_datain !== 32'h108) $display("FAIL fpp_status_after got %h exp 108", bus.dmem_datain); else passed++;
    total++; if (con_ovf !== 1'b0) $display("FAIL fpp_no_ovf got %0h exp 0", con_ovf); else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.con_ready = 1'b1;
      #1;
      e = (i < 7) ? 8'(8'h21 + i) : 8'h55;
      total++;
      if ({bus.con_valid, bus.con_data} !== {1'b1, e})
        $display("FAIL fpp_drain%0d got v=%0h d=%h exp v=1 d=%h", i, bus.con_valid, bus.con_data, e);
      else passed++;
    end
    @(negedge clk);
    total++; if (bus.con_valid !== 1'b0) $display("FAIL fpp_drained got %0h exp 0", bus.con_valid); else passed++;
    bus.con_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] e;
    bus.con_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(CON, 32'h30 + i);
    load(STAT, rd);
    total++; if (rd !== 32'h108) $display("FAIL ovf_status_8 got %h exp 108", rd); else passed++;
    store(CON, 32'h38);
    load(STAT, rd);
    total++; if (rd !== 32'h308) $display("FAIL ovf_status_9 got %h exp 308", rd); else passed++;
    total++; if (con_ovf !== 1'b1) $display("FAIL ovf_flag got %0h exp 1", con_ovf); else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.con_ready = 1'b1;
      #1;
      e = 8'(8'h30 + i);
      total++;
      if ({bus.con_valid, bus.con_data} !== {1'b1, e})
        $display("FAIL ovf_drain%0d got v=%0h d=%h exp v=1 d=%h", i, bus.con_valid, bus.con_data, e);
      else passed++;
    end
    @(negedge clk);
    total++; if (bus.con_valid !== 1'b0) $display("FAIL ovf_drained got %0h exp 0", bus.con_valid); else passed++;
    bus.con_ready = 1'b0;
    load(STAT, rd);
    total++; if (rd !== 32'h200) $display("FAIL ovf_sticky_status got %h exp 200", rd); else passed++;
  endtask
`else
  task automatic test_console_disabled();
    bus.con_ready = 1'b1;
    store(CON, 32'h41);
    total++; if (bus.con_valid !== 1'b0) $display("FAIL dis_con_valid got %0h exp 0", bus.con_valid); else passed++;
    total++; if (bus.con_data !== 8'h00) $display("FAIL dis_con_data got %h exp 00", bus.con_data); else passed++;
    bus.con_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(CON, 32'h30 + i);
    load(STAT, rd);
    total++; if (rd !== 32'h0) $display("FAIL dis_status got %h exp 0", rd); else passed++;
    total++; if (con_ovf !== 1'b0) $display("FAIL dis_con_ovf got %0h exp 0", con_ovf); else passed++;
  endtask
`endif

  task automatic test_reset_mid_drain();
    bus.con_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(CON, 32'h60 + i);
`ifdef RV_MMIO_CONSOLE_EN
    total++; if (con_ovf !== 1'b1) $display("FAIL rmd_pre_ovf got %0h exp 1", con_ovf); else passed++;
`endif
    total++; if (halt !== 1'b1) $display("FAIL rmd_pre_halt got %0h exp 1", halt); else passed++;
    @(negedge clk);
    bus.con_ready = 1'b1;
    bus.dmem_addr = STAT;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    total++; if (bus.con_valid !== 1'b0) $display("FAIL rmd_con_valid got %0h exp 0", bus.con_valid); else passed++;
    total++; if (bus.con_data !== 8'h00) $display("FAIL rmd_con_data got %h exp 00", bus.con_data); else passed++;
    total++; if (halt !== 1'b0) $display("FAIL rmd_halt got %0h exp 0", halt); else passed++;
    total++; if (halt_code !== 32'h0) $display("FAIL rmd_halt_code got %h exp 0", halt_code); else passed++;
    total++; if (con_ovf !== 1'b0) $display("FAIL rmd_con_ovf got %0h exp 0", con_ovf); else passed++;
    total++; if (bus.dmem_datain !== 32'h0) $display("FAIL rmd_status got %h exp 0", bus.dmem_datain); else passed++;
    @(negedge clk);
    rst           = 1'b1;
    bus.con_ready = 1'b0;
    load(32'h40, rd);
    total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rmd_ram_kept got %h exp deadbeef", rd); else passed++;
    load(STAT, rd);
    total++; if (rd !== 32'h0) $display("FAIL rmd_status_after got %h exp 0", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_halt();
`ifdef RV_MMIO_CONSOLE_EN
    test_console();
    test_full_push_pop();
    test_overflow();
`else
    test_console_disabled();
`endif
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rv_dmem_mmio.md
# rv_dmem_mmio

Data-memory subsystem that sits directly downstream of the multicycle RISC-V core's data port (`dmem_addr` / `dmem_dataout` / `memrw` / `dmem_datain`). It provides:
- word RAM;
- a memory-mapped console byte FIFO, drained by the testbench through a valid/ready port;
- a sticky halt/exit-code register, used by self-checking programs to report success or failure.

The core has no stall input, so every access completes in the cycle it is presented.

## Interface
Parameters:
- `DPWIDTH`, 32, data and address width.
- `RAMWORDS`, 1024, RAM depth in words (power of two).
- `FIFODEPTH`, 8, console FIFO depth in bytes (power of two, ≥2).
- `MMIO_BASE`, 32'hFFFF_0000, base address of the MMIO window.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `dmem_addr`  in  DPWIDTH  byte address from core.
- `dmem_dataout`  in  DPWIDTH  store data from core.
- `memrw`  in  1  1 = write this cycle, 0 = read.
- `dmem_datain`  out  DPWIDTH  load data to core (combinational).
- `con_data`  out  8  console byte at FIFO head.
- `con_valid`  out  1  FIFO non-empty.
- `con_ready`  in  1  sink accepts `con_data` this cycle.
- `halt`  out  1  sticky program-finished flag.
- `halt_code`  out  DPWIDTH  value written to HALT.
- `con_ovf`  out  1  sticky console-overflow flag.

## Operation
- Decode:
  - RAM when `dmem_addr < RAMWORDS*4`; index = `dmem_addr[log2(RAMWORDS)+1:2]`; `addr[1:0]` ignored.
  - MMIO when `dmem_addr[DPWIDTH-1:4] == MMIO_BASE[DPWIDTH-1:4]`.
  - Everything else is unmapped: reads return 0, writes are ignored.
- RAM: read is combinational from the current address. Write happens on the rising edge when `memrw=1`, as a full word. RAM contents are not reset.
- MMIO offsets (from package):
  - +0x0 CONSOLE: write pushes `dmem_dataout[7:0]`; reads 0.
  - +0x4 STATUS: read-only, `{.., con_ovf[9], full[8], count[7:0]}`, zero-extended.
  - +0x8 HALT: write sets `halt=1` and latches `halt_code=dmem_dataout`; reads `halt_code`.
  - +0xC: reserved; reads 0.
- Each cycle with `memrw=1` is one distinct write; the core holds `memrw` high for exactly one cycle per store.
- HALT is sticky. The first write wins; later HALT writes are ignored until reset. After `halt`, RAM and console writes still function.
- FIFO:
  - Pop when `con_valid && con_ready`.
  - Push accepted when not full, or when full and a pop occurs in the same cycle.
  - Push to a full FIFO with no pop drops the byte and sets `con_ovf` (sticky); count is unchanged.
  - Push and pop together on an empty FIFO: `con_valid` is 0, so no pop happens; the push is accepted and count becomes 1.
  - `con_data` must stay stable while `con_valid && !con_ready`.
- Reset (`rst=0`, asynchronous), all outputs:
  - `halt=0`, `halt_code=0`, `con_ovf=0`, `con_valid=0`.
  - FIFO emptied (pointers and count 0).
  - `con_data` = 0 while the FIFO is empty.
  - Reset during a drain discards queued bytes.

## Timing
- Load latency: 0 cycles. `dmem_datain` is valid in the same cycle as `dmem_addr`, so the core's MDR can capture it at the next edge.
- Store: takes effect at the rising edge in which `memrw=1`. A read of the same address in the next cycle returns the new data.
- Console push at edge N: `con_valid=1` from edge N onward, with byte visible on `con_data`.
- STATUS reflects state after the last edge; it does not include the push of the current cycle.
- Throughput: one pop per cycle with `con_ready` held high.

## Configuration
- Macro `RV_MMIO_CONSOLE_EN`.
- Defined: console FIFO and overflow logic are present, as described above.
- Undefined:
  - FIFO and `rv_byte_fifo` are not instantiated.
  - `con_valid=0`, `con_data=0`, `con_ovf=0`.
  - CONSOLE writes are ignored; STATUS reads 0.
  - RAM and HALT are unchanged.

## Structure
- Package `rv_mem_pkg`:
  - MMIO offset constants: `CONSOLE_OFS`, `STATUS_OFS`, `HALT_OFS`.
  - STATUS bit positions.
  - Region-decode enumeration: `REG_RAM`, `REG_MMIO`, `REG_NONE`.
- Sub-module `rv_byte_fifo`:
  - 8-bit, parameterized depth.
  - Ports: push, push_data, pop_ready, valid, head, count, full, ovf.
  - Asynchronous active-low reset.
- Top level holds the decode, RAM array, HALT register, and read mux.

## Test plan
- RAM: store 32'hDEADBEEF to 0x40, then load 0x40 → `dmem_datain=32'hDEADBEEF`. Load 0x44 after reset-free power-up → any value, no X on decode. Load 0x2000 (unmapped) → 0.
- Console: `con_ready=1`, store 0x4F, 0x4B, 0x0A to BASE+0 → `con_data` sequence 0x4F, 0x4B, 0x0A, each valid one cycle after its push.
- Overflow: `con_ready=0`, push 9 bytes → STATUS = 0x108 after 8 bytes. The 9th byte is dropped and STATUS = 0x308. Then raise `con_ready` → 8 bytes drain in order.
- Full with simultaneous push and pop: FIFO full, `con_ready=1`, push 0x55 → accepted, count stays 8, `con_ovf` stays 0, and 0x55 emerges last.
- Halt: store 1 to BASE+8, then store 7 → `halt=1`, `halt_code=1`, load BASE+8 = 1.
- Reset mid-drain: 5 bytes queued, `rst=0` asynchronously mid-cycle → `con_valid=0`, `halt=0`, STATUS=0 immediately; RAM word at 0x40 is retained.
